fc_neuron_seq: RTL and testbench

Time-multiplexed, parametrised fully-connected neuron. It accumulates IN signed input×weight products, LANES per beat, onto a bias, then applies an optional ReLU. It replaces the fully-unrolled constant-weight multiplier/adder-tree neuron in FC layers where area matters more than latency. Weights stream in alongside the inputs, so one instance can serve any output neuron.

---
 rtl/fc_neuron_seq.sv | 135 +++++++++++++
 tb/tb_fc_neuron_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed fully-connected neuron: streams LANES input/weight pairs per beat,
// accumulates their signed products onto a bias and applies an optional ReLU.
module fc_neuron_seq #(
   parameter int WIDTH     = 8,
   parameter int W_WIDTH   = 8,
   parameter int IN        = 400,
   parameter int LANES     = 4,
   parameter int ACC_WIDTH = WIDTH + W_WIDTH + $clog2(IN)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       relu_en,
   input  logic [ACC_WIDTH-1:0]       bias,
   input  logic                       clear,
   input  logic                       x_valid,
   output logic                       x_ready,
   input  logic [LANES*WIDTH-1:0]     x_data,
   input  logic [LANES*W_WIDTH-1:0]   w_data,
   output logic                       z_valid,
   input  logic                       z_ready,
   output logic [ACC_WIDTH-1:0]       z,
   output logic                       busy
);

   localparam int BEATS      = (IN + LANES - 1) / LANES;
   localparam int LAST_LANES = IN - (BEATS - 1) * LANES;
   localparam int PW         = WIDTH + W_WIDTH;
   localparam int CW         = $clog2(BEATS + 1);

   typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

   state_e                       r_state;
   logic [CW-1:0]                r_beat_cnt;
   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic signed [ACC_WIDTH-1:0]  r_s1_sum;
   logic signed [ACC_WIDTH-1:0]  r_z;
   logic                         r_s1_vld;
   logic                         r_relu;
   logic                         r_x_ready;
   logic                         r_z_valid;
   logic                         r_busy;

   logic signed [WIDTH-1:0]      w_x [LANES];
   logic signed [W_WIDTH-1:0]    w_w [LANES];
   logic signed [ACC_WIDTH-1:0]  w_sum;
   logic signed [ACC_WIDTH-1:0]  w_acc_nxt;
   logic signed [ACC_WIDTH-1:0]  w_z_nxt;
   logic                         w_accept;
   logic                         w_last_beat;

   assign w_accept    = x_valid && r_x_ready;
   assign w_last_beat = (r_beat_cnt == CW'(BEATS - 1));

   // Stage 1: masked lane products summed at full precision.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         w_x[i] = x_data[i*WIDTH +: WIDTH];
         w_w[i] = w_data[i*W_WIDTH +: W_WIDTH];
         if (!(w_last_beat && (i >= LAST_LANES))) begin
            w_sum = w_sum + ACC_WIDTH'(PW'(w_x[i]) * PW'(w_w[i]));
         end
      end
   end

   // Stage 2 only adds when stage 1 holds a fresh beat.
   assign w_acc_nxt = r_s1_vld ? (r_acc + r_s1_sum) : r_acc;
   assign w_z_nxt   = (r_relu && w_acc_nxt[ACC_WIDTH-1]) ? '0 : w_acc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_beat_cnt <= '0;
         r_acc      <= '0;
         r_s1_sum   <= '0;
         r_z        <= '0;
         r_s1_vld   <= 1'b0;
         r_relu     <= 1'b0;
         r_x_ready  <= 1'b0;
         r_z_valid  <= 1'b0;
         r_busy     <= 1'b0;
      end else if (clear) begin
         r_state   <= StIdle;
         r_s1_vld  <= 1'b0;
         r_x_ready <= 1'b0;
         r_z_valid <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_acc    <= w_acc_nxt;
         r_s1_vld <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_state    <= StAccum;
                  r_acc      <= bias;
                  r_relu     <= relu_en;
                  r_beat_cnt <= '0;
                  r_x_ready  <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            StAccum: begin
               if (w_accept) begin
                  r_s1_sum   <= w_sum;
                  r_s1_vld   <= 1'b1;
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (w_last_beat) begin
                     r_x_ready <= 1'b0;
                     r_state   <= StDrain;
                  end
               end
            end
            StDrain: begin
               r_z       <= w_z_nxt;
               r_z_valid <= 1'b1;
               r_state   <= StDone;
            end
            StDone: begin
               if (z_ready) begin
                  r_z_valid <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= StIdle;
               end
            end
         endcase
      end
   end

   assign x_ready = r_x_ready;
   assign z_valid = r_z_valid;
   assign z       = r_z;
   assign busy    = r_busy;

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Bench for fc_neuron_seq: three instances (IN=8, 10, 400) driven one at a time from a
// vector table, hand-written abort sequences and random runs against a dot-product model.
module tb_fc_neuron_seq;

   logic        clk;
   logic        rst_n;
   logic        relu_en;
   logic        clear;
   logic [2:0]  start_v;
   logic [2:0]  xv_v;
   logic [2:0]  zr_v;
   logic [2:0]  xr_v;
   logic [2:0]  zv_v;
   logic [2:0]  busy_v;
   logic [31:0] x_data;
   logic [31:0] w_data;
   logic [24:0] bias_all;
   logic [18:0] z8;
   logic [19:0] z10;
   logic [24:0] z400;
   int          z_s [3];

   int xs [400];
   int ws [400];
   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int    sel;
      bit    relu;
      int    bias;
      int    xv;
      int    wv;
      int    padw;
      bit    gaps;
      int    zdelay;
      int    exp_z;
      string name;
   } vec_t;

   vec_t vecs [5];

   fc_neuron_seq #(.WIDTH(8), .W_WIDTH(8), .IN(8), .LANES(4)) u_n8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .relu_en(relu_en),
      .bias(bias_all[18:0]), .clear(clear), .x_valid(xv_v[0]), .x_ready(xr_v[0]),
      .x_data(x_data), .w_data(w_data), .z_valid(zv_v[0]), .z_ready(zr_v[0]),
      .z(z8), .busy(busy_v[0])
   );

   fc_neuron_seq #(.WIDTH(8), .W_WIDTH(8), .IN(10), .LANES(4)) u_n10 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .relu_en(relu_en),
      .bias(bias_all[19:0]), .clear(clear), .x_valid(xv_v[1]), .x_ready(xr_v[1]),
      .x_data(x_data), .w_data(w_data), .z_valid(zv_v[1]), .z_ready(zr_v[1]),
      .z(z10), .busy(busy_v[1])
   );

   fc_neuron_seq #(.WIDTH(8), .W_WIDTH(8), .IN(400), .LANES(4)) u_n400 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .relu_en(relu_en),
      .bias(bias_all), .clear(clear), .x_valid(xv_v[2]), .x_ready(xr_v[2]),
      .x_data(x_data), .w_data(w_data), .z_valid(zv_v[2]), .z_ready(zr_v[2]),
      .z(z400), .busy(busy_v[2])
   );

   assign z_s[0] = int'($signed(z8));
   assign z_s[1] = int'($signed(z10));
   assign z_s[2] = int'($signed(z400));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp_v);
      n_total++;
      if (got == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
   endtask

   function automatic int n_of(input int sel);
      return (sel == 0) ? 8 : (sel == 1) ? 10 : 400;
   endfunction

   // Reference: plain dot product over the first n pairs, plus bias, then ReLU.
   function automatic int model(input int n, input bit relu, input int b);
      int acc;
      acc = b;
      for (int i = 0; i < n; i++) acc += xs[i] * ws[i];
      return (relu && acc < 0) ? 0 : acc;
   endfunction

   task automatic drive_beat(input int b, input int n, input int pad_w);
      for (int l = 0; l < 4; l++) begin
         int idx;
         idx = b * 4 + l;
         x_data[l*8 +: 8] = 8'(xs[idx]);
         w_data[l*8 +: 8] = (idx < n) ? 8'(ws[idx]) : 8'(pad_w);
      end
   endtask

   task automatic run_eval(input int sel, input bit relu, input int b, input int pad_w,
                           input bit gaps, input int zdelay, input bit poke,
                           input int exp_z, input string name);
      int n, beats, got, cyc, z_hold;
      bit stable;
      n     = n_of(sel);
      beats = (n + 3) / 4;
      got   = 0;
      cyc   = 0;
      @(negedge clk);
      bias_all       = 25'(b);
      relu_en        = relu;
      start_v[sel]   = 1'b1;
      @(negedge clk);
      start_v[sel]   = 1'b0;
      check({name, "_busy_start"}, int'(busy_v[sel]), 1);
      while (got < beats && cyc < 5000) begin
         drive_beat(got, n, pad_w);
         xv_v[sel]    = gaps ? 1'($urandom_range(0, 2) != 0) : 1'b1;
         start_v[sel] = poke && (cyc == 1);
         if (xv_v[sel] && xr_v[sel]) got++;
         @(negedge clk);
         cyc++;
      end
      xv_v[sel]    = 1'b0;
      start_v[sel] = 1'b0;
      check({name, "_beats"}, got, beats);
      check({name, "_xready_drop"}, int'(xr_v[sel]), 0);
      check({name, "_zvalid_early"}, int'(zv_v[sel]), 0);
      @(negedge clk);
      check({name, "_zvalid_t2"}, int'(zv_v[sel]), 1);
      check({name, "_z"}, z_s[sel], exp_z);
      z_hold       = z_s[sel];
      stable       = 1'b1;
      start_v[sel] = poke;
      repeat (zdelay) begin
         @(negedge clk);
         if (!zv_v[sel] || z_s[sel] != z_hold) stable = 1'b0;
      end
      if (zdelay > 0) check({name, "_hold"}, int'(stable), 1);
      zr_v[sel] = 1'b1;
      @(negedge clk);
      zr_v[sel]    = 1'b0;
      start_v[sel] = 1'b0;
      check({name, "_zvalid_clr"}, int'(zv_v[sel]), 0);
      check({name, "_idle"}, int'(busy_v[sel]), 0);
      check({name, "_z_keep"}, z_s[sel], exp_z);
   endtask

   task automatic fill(input int xv, input int wv);
      for (int i = 0; i < 400; i++) begin
         xs[i] = xv;
         ws[i] = wv;
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      relu_en  = 1'b0;
      clear    = 1'b0;
      start_v  = '0;
      xv_v     = '0;
      zr_v     = '0;
      x_data   = '0;
      w_data   = '0;
      bias_all = '0;

      vecs[0] = '{0, 1'b0, 0,    3,    2,    0,   1'b0, 3, 48,      "t1_basic"};
      vecs[1] = '{1, 1'b0, 0,    1,    1,    127, 1'b0, 1, 10,      "t2_mask"};
      vecs[2] = '{0, 1'b1, 5,    -128, 127,  0,   1'b0, 0, 0,       "t3_relu"};
      vecs[3] = '{0, 1'b0, 5,    -128, 127,  0,   1'b0, 0, -130043, "t3_norelu"};
      vecs[4] = '{2, 1'b0, -1,   -128, -128, 0,   1'b1, 5, 6553599, "t4_full"};

      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check("rst_xready", int'(xr_v[s]), 0);
         check("rst_zvalid", int'(zv_v[s]), 0);
         check("rst_busy", int'(busy_v[s]), 0);
         check("rst_z", z_s[s], 0);
      end
      rst_n = 1'b1;

      for (int k = 0; k < 5; k++) begin
         fill(vecs[k].xv, vecs[k].wv);
         run_eval(vecs[k].sel, vecs[k].relu, vecs[k].bias, vecs[k].padw, vecs[k].gaps,
                  vecs[k].zdelay, 1'b0, vecs[k].exp_z, vecs[k].name);
      end

      // Asynchronous reset in the middle of the first beat.
      fill(3, 2);
      @(negedge clk);
      bias_all   = '0;
      relu_en    = 1'b0;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      drive_beat(0, 8, 0);
      xv_v[0] = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      xv_v[0] = 1'b0;
      #1;
      check("t5_rst_busy", int'(busy_v[0]), 0);
      check("t5_rst_xready", int'(xr_v[0]), 0);
      check("t5_rst_zvalid", int'(zv_v[0]), 0);
      check("t5_rst_z", z_s[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_eval(0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 48, "t5_after_rst");

      // Synchronous clear during ACCUM, colliding with start and a beat handshake.
      @(negedge clk);
      bias_all   = 25'(100);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      drive_beat(0, 8, 0);
      xv_v[0] = 1'b1;
      @(negedge clk);
      clear      = 1'b1;
      start_v[0] = 1'b1;
      drive_beat(1, 8, 0);
      @(negedge clk);
      clear      = 1'b0;
      start_v[0] = 1'b0;
      xv_v[0]    = 1'b0;
      check("t5_clr_busy", int'(busy_v[0]), 0);
      check("t5_clr_xready", int'(xr_v[0]), 0);
      check("t5_clr_zvalid", int'(zv_v[0]), 0);
      @(negedge clk);
      check("t5_clr_stay_idle", int'(busy_v[0]), 0);
      run_eval(0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 48, "t5_after_clr");

      // start held in ACCUM and DONE is ignored; restart right after the handshake works.
      run_eval(0, 1'b0, 0, 0, 1'b0, 3, 1'b1, 48, "t6_poke");
      fill(-7, 9);
      run_eval(1, 1'b0, 3, 0, 1'b0, 0, 1'b0, model(10, 1'b0, 3), "t6_restart");

      for (int k = 0; k < 8; k++) begin
         int sel, b, pw;
         bit relu;
         for (int i = 0; i < 400; i++) begin
            xs[i] = int'($urandom_range(0, 255)) - 128;
            ws[i] = int'($urandom_range(0, 255)) - 128;
         end
         sel  = int'($urandom_range(0, 2));
         relu = 1'($urandom_range(0, 1));
         b    = int'($urandom_range(0, 40000)) - 20000;
         pw   = int'($urandom_range(0, 255)) - 128;
         run_eval(sel, relu, b, pw, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  1'b0, model(n_of(sel), relu, b), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
